bit_serial_adder_seq: RTL and testbench
=======================================

Name: bit_serial_adder_seq

Overview:
- Bit-serial adder sequencer; sits directly upstream of the half-adder cell and drives it.
- Accepts two WIDTH-bit operands through a valid/ready handshake.
- Streams the operands LSB-first through two cascaded half-adder stages plus a carry flop, one bit per clock.
- Collects the sum bits into a result register and presents sum and final carry on a valid/ready output handshake.
- Targets small tile-area designs where a parallel WIDTH-bit adder is too large.

Parameters:
- WIDTH, 8, operand and sum width in bits; legal range 2..32.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  reset; asynchronous, active-high.
- in_valid  input  1  operand pair valid.
- in_ready  output  1  block can accept operands; high only in IDLE.
- in_a  input  WIDTH  operand A, unsigned.
- in_b  input  WIDTH  operand B, unsigned.
- in_sub  input  1  subtract request; ignored unless SERIAL_SUB_EN is defined.
- out_valid  output  1  result valid; high only in DONE.
- out_ready  input  1  consumer accepts result.
- out_sum  output  WIDTH  result bits.
- out_carry  output  1  final carry-out (add) or no-borrow flag (subtract).
- busy  output  1  high in RUN.
- bit_cnt  output  clog2(WIDTH)  index of the bit being processed.

Behaviour:
- Interface decision: one clock, clk; reset rst is asynchronous and active-high.
- Reset:
  - state=IDLE.
  - All shift registers, carry flop, bit_cnt, out_sum and out_carry are cleared to 0.
  - out_valid=0, busy=0, in_ready=1 (decoded from state).
- FSM has three states: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready: latch in_a and in_b into shift registers sa and sb.
  - Carry flop c <= 0 (or 1 if subtracting); bit_cnt <= 0; go to RUN.
- RUN, each edge:
  - First half-adder: h = sa[0] ^ sb[0], g = sa[0] & sb[0].
  - Second half-adder: s = h ^ c, p = h & c; c <= g | p.
  - Sum shift register ss is shifted right with s entering the MSB.
  - sa and sb are shifted right by one; bit_cnt increments.
  - At the edge where bit_cnt==WIDTH-1: out_sum <= final ss value including this cycle's s; out_carry <= final c; go to DONE.
- Latency: out_valid rises exactly WIDTH edges after the accepting edge.
- DONE:
  - out_valid=1; out_sum and out_carry are stable.
  - On out_valid&&out_ready: go to IDLE.
  - Throughput is one operation per WIDTH+2 cycles minimum.
- in_valid outside IDLE is ignored; in_ready=0 during RUN and DONE. Inputs may change freely during RUN.
- out_ready outside DONE has no effect.
- out_sum and out_carry hold the last result until the next DONE entry; they are meaningful only when out_valid=1.
- Arithmetic is modulo 2^WIDTH; overflow is reported solely via out_carry.
- Reset asserted mid-RUN or mid-DONE aborts the operation immediately (asynchronous) and applies the reset values above. No partial result is emitted.
- bit_cnt is held at 0 in IDLE and DONE.

Optional Feature:
- Macro: SERIAL_SUB_EN.
- Defined:
  - in_sub is sampled at the accepting edge.
  - If in_sub=1: sb loads ~in_b and the carry flop loads 1 (two's-complement subtract A-B).
  - out_carry=1 means no borrow (A>=B); out_carry=0 means borrow.
- Undefined:
  - in_sub is unconnected internally; the block always adds and the carry flop always starts at 0.
  - No subtract logic is synthesised.

Test Plan:
- Add: WIDTH=8, in_a=0x35, in_b=0x4A, in_sub=0, out_ready=1 -> out_valid high 8 edges after accept; out_sum=0x7F, out_carry=0; in_ready high one cycle after the output handshake.
- Overflow: in_a=0xFF, in_b=0x01 -> out_sum=0x00, out_carry=1; in_a=0xFF, in_b=0xFF -> out_sum=0xFE, out_carry=1.
- Backpressure and ignored input: hold out_ready=0 for 5 cycles in DONE -> out_valid stays 1, out_sum/out_carry unchanged. in_valid=1 with new operands during RUN -> in_ready=0 and the operands are not accepted.
- Reset mid-operation: assert rst at bit_cnt=3 during RUN -> state IDLE without a clock edge; out_valid=0, out_sum=0, busy=0, in_ready=1; next operation 0x02+0x03 gives 0x05, out_carry=0.
- SERIAL_SUB_EN: 0x10-0x01 -> out_sum=0x0F, out_carry=1; 0x01-0x02 -> out_sum=0xFF, out_carry=0. Without the macro, in_sub=1 with 0x10,0x01 -> out_sum=0x11, out_carry=0.

Source files
------------

// File: rtl/bit_serial_adder_seq.sv
// Bit-serial adder sequencer: streams two WIDTH-bit operands LSB-first through two half-adder
// stages and a carry flop. Optional subtract mode is enabled by defining SERIAL_SUB_EN.
module bit_serial_adder_seq #(
  parameter int WIDTH = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [WIDTH-1:0]           in_a,
  input  logic [WIDTH-1:0]           in_b,
  input  logic                       in_sub,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [WIDTH-1:0]           out_sum,
  output logic                       out_carry,
  output logic                       busy,
  output logic [$clog2(WIDTH)-1:0]   bit_cnt
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_sa;
  logic [WIDTH-1:0] r_sb;
  logic [WIDTH-1:0] r_ss;
  logic             r_c;
  logic [CW-1:0]    r_bit_cnt;
  logic [WIDTH-1:0] r_sum;
  logic             r_carry;

  logic [WIDTH-1:0] w_sb_load;
  logic             w_c_load;
  logic             w_h;
  logic             w_g;
  logic             w_s;
  logic             w_p;
  logic             w_c_next;
  logic [WIDTH-1:0] w_ss_next;

`ifdef SERIAL_SUB_EN
  // Two's-complement subtract: invert B and inject the +1 through the carry flop.
  assign w_sb_load = in_sub ? ~in_b : in_b;
  assign w_c_load  = in_sub;
`else
  logic w_unused_sub;
  assign w_unused_sub = in_sub;
  assign w_sb_load    = in_b;
  assign w_c_load     = 1'b0;
`endif

  assign w_h       = r_sa[0] ^ r_sb[0];
  assign w_g       = r_sa[0] & r_sb[0];
  assign w_s       = w_h ^ r_c;
  assign w_p       = w_h & r_c;
  assign w_c_next  = w_g | w_p;
  assign w_ss_next = {w_s, r_ss[WIDTH-1:1]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= IDLE;
      r_sa      <= '0;
      r_sb      <= '0;
      r_ss      <= '0;
      r_c       <= 1'b0;
      r_bit_cnt <= '0;
      r_sum     <= '0;
      r_carry   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_sa      <= in_a;
            r_sb      <= w_sb_load;
            r_ss      <= '0;
            r_c       <= w_c_load;
            r_bit_cnt <= '0;
            r_state   <= RUN;
          end
        end
        RUN: begin
          r_sa <= r_sa >> 1;
          r_sb <= r_sb >> 1;
          r_ss <= w_ss_next;
          r_c  <= w_c_next;
          // The last bit's sum and carry are captured straight from the adder, not the flops.
          if (r_bit_cnt == LAST_BIT) begin
            r_sum     <= w_ss_next;
            r_carry   <= w_c_next;
            r_bit_cnt <= '0;
            r_state   <= DONE;
          end else begin
            r_bit_cnt <= r_bit_cnt + CW'(1);
          end
        end
        DONE: begin
          if (out_ready) begin
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign in_ready  = (r_state == IDLE);
  assign out_valid = (r_state == DONE);
  assign busy      = (r_state == RUN);
  assign out_sum   = r_sum;
  assign out_carry = r_carry;
  assign bit_cnt   = r_bit_cnt;

endmodule

// File: tb/tb_bit_serial_adder_seq.sv
// Scoreboard bench for bit_serial_adder_seq: directed operand pairs push expected results,
// a negedge monitor pops and compares on every output handshake.
module tb_bit_serial_adder_seq;

  localparam int WIDTH = 8;
  localparam int CW    = $clog2(WIDTH);

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic             in_sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_sum;
  logic             out_carry;
  logic             busy;
  logic [CW-1:0]    bit_cnt;

  int n_tests = 0;
  int n_fail  = 0;
  logic [WIDTH:0] exp_q[$];

  bit_serial_adder_seq #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_sub    (in_sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_carry (out_carry),
    .busy      (busy),
    .bit_cnt   (bit_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end else begin
      $display("[TB] ok   %s: 0x%0h", name, act);
    end
  endtask

  // Monitor: one comparison per output handshake.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_output", {23'd0, out_carry, out_sum}, 32'h1FF);
      end else begin
        logic [WIDTH:0] e;
        e = exp_q.pop_front();
        chk("result_sum",   {24'd0, out_sum}, {24'd0, e[WIDTH-1:0]});
        chk("result_carry", {31'd0, out_carry}, {31'd0, e[WIDTH]});
      end
    end
  end

  task automatic wait_ready();
    int t = 0;
    while (!in_ready && t < 100) begin
      @(posedge clk); #1;
      t++;
    end
    if (!in_ready) chk("in_ready_timeout", 32'd0, 32'd1);
  endtask

  // Issue one operation; bp = DONE cycles with out_ready low, ign = poke new operands during RUN.
  task automatic run_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic sub,
                        input logic [WIDTH-1:0] esum, input logic ecarry,
                        input int bp, input bit ign);
    logic [WIDTH-1:0] held_sum;
    logic             held_carry;
    wait_ready();
    in_a = a; in_b = b; in_sub = sub; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    exp_q.push_back({ecarry, esum});
    chk("busy_after_accept", {31'd0, busy}, 32'd1);
    if (ign) begin
      in_valid = 1'b1; in_a = ~a; in_b = 8'h5A; in_sub = ~sub;
      chk("in_ready_low_in_run", {31'd0, in_ready}, 32'd0);
    end
    repeat (WIDTH - 1) begin
      @(posedge clk); #1;
    end
    chk("out_valid_low_at_w_minus_1", {31'd0, out_valid}, 32'd0);
    if (ign) begin
      chk("operands_ignored_busy", {31'd0, busy}, 32'd1);
      in_valid = 1'b0;
    end
    if (bp > 0) out_ready = 1'b0;
    @(posedge clk); #1;
    chk("out_valid_at_w_edges", {31'd0, out_valid}, 32'd1);
    if (bp > 0) begin
      held_sum   = esum;
      held_carry = ecarry;
      repeat (bp) begin
        @(posedge clk); #1;
        chk("bp_out_valid_held", {31'd0, out_valid}, 32'd1);
        chk("bp_sum_stable", {24'd0, out_sum}, {24'd0, held_sum});
        chk("bp_carry_stable", {31'd0, out_carry}, {31'd0, held_carry});
      end
      out_ready = 1'b1;
    end
    @(posedge clk); #1;
    chk("in_ready_after_handshake", {31'd0, in_ready}, 32'd1);
    chk("out_valid_after_handshake", {31'd0, out_valid}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0; in_sub = 1'b0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_in_ready",  {31'd0, in_ready}, 32'd1);
    chk("reset_out_valid", {31'd0, out_valid}, 32'd0);
    chk("reset_busy",      {31'd0, busy}, 32'd0);
    chk("reset_out_sum",   {24'd0, out_sum}, 32'd0);
    chk("reset_out_carry", {31'd0, out_carry}, 32'd0);
    chk("reset_bit_cnt",   {29'd0, bit_cnt}, 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    run_op(8'h35, 8'h4A, 1'b0, 8'h7F, 1'b0, 0, 1'b0);
    run_op(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 0, 1'b0);
    run_op(8'hFF, 8'hFF, 1'b0, 8'hFE, 1'b1, 0, 1'b0);
    run_op(8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0, 5, 1'b1);
    run_op(8'hFF, 8'hFF, 1'b0, 8'hFE, 1'b1, 0, 1'b0);

    // Abort mid-RUN with an asynchronous reset.
    wait_ready();
    in_a = 8'h11; in_b = 8'h22; in_sub = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
    end
    chk("bit_cnt_before_abort", {29'd0, bit_cnt}, 32'd3);
    #2 rst = 1'b1;
    #1;
    chk("abort_in_ready",  {31'd0, in_ready}, 32'd1);
    chk("abort_busy",      {31'd0, busy}, 32'd0);
    chk("abort_out_valid", {31'd0, out_valid}, 32'd0);
    chk("abort_out_sum",   {24'd0, out_sum}, 32'd0);
    chk("abort_bit_cnt",   {29'd0, bit_cnt}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    run_op(8'h02, 8'h03, 1'b0, 8'h05, 1'b0, 0, 1'b0);

`ifdef SERIAL_SUB_EN
    run_op(8'h10, 8'h01, 1'b1, 8'h0F, 1'b1, 0, 1'b0);
    run_op(8'h01, 8'h02, 1'b1, 8'hFF, 1'b0, 0, 1'b0);
`else
    run_op(8'h10, 8'h01, 1'b1, 8'h11, 1'b0, 0, 1'b0);
`endif

    repeat (4) @(posedge clk);
    #1;
    chk("scoreboard_drained", exp_q.size(), 32'd0);
    chk("idle_at_end", {31'd0, in_ready}, 32'd1);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
